// File: rtl/instruction_fetch_if.sv
// Bus bundle for the fetch stage: instruction-memory req/gnt/rvalid channel
// plus the valid/ready hand-off toward decode.
interface instruction_fetch_if #(
    parameter int BITS = 32,
    parameter int IW   = 32
);
    logic            imem_req;
    logic [BITS-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [IW-1:0]   imem_rdata;
    logic            if_valid;
    logic [IW-1:0]   if_instr;
    logic [BITS-1:0] if_pc;
    logic            id_ready;

    // master is the fetch stage itself; slave is the memory/decode side
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, holds the returned word for decode,
// stalls the PC until a fetch is granted, and drops wrong-path responses on flush.
module instruction_fetch #(
    parameter int BITS = 32,
    parameter int IW   = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [BITS-1:0]        pc,
    input  logic                   flush,
    instruction_fetch_if.master    bus,
    output logic                   pc_stall,
    output logic                   misalign,
    output logic [31:0]            fetch_count
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [BITS-1:0] req_pc;
    logic            discard;
    logic            valid_q;
    logic [IW-1:0]   instr_q;
    logic [BITS-1:0] pc_q;

    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = pc_q;

    // The PC only moves on a granted request or a redirect, so each PC is fetched once.
    assign pc_stall = !(flush || ((state == REQ) && bus.imem_gnt));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= REQ;
            req_pc      <= '0;
            discard     <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                REQ: begin
                    // A flush in the grant cycle still issues the old PC, but its response is dead.
                    if (bus.imem_gnt) begin
                        req_pc  <= pc;
                        discard <= flush;
                        if (pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (discard || flush) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            instr_q <= bus.imem_rdata;
                            pc_q    <= req_pc;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        valid_q <= 1'b0;
                        state   <= REQ;
                    end else if (bus.id_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        valid_q     <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected deliveries into a
// scoreboard queue that a negedge monitor drains whenever decode accepts a word.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } delivery_t;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic        misalign;
    logic [31:0] fetch_count;

    instruction_fetch_if #(.BITS(32), .IW(32)) bus ();

    instruction_fetch #(.BITS(32), .IW(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc          (pc),
        .flush       (flush),
        .bus         (bus),
        .pc_stall    (pc_stall),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    delivery_t   expQ[$];
    int          vectors;
    int          miscompares;
    logic [31:0] expCount;
    logic        expMisalign;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expected delivery.
    always @(negedge clk) begin
        if (rstn && bus.if_valid && bus.id_ready && !flush) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_delivery: got instr 0x%08h pc 0x%08h, expected none", bus.if_instr, bus.if_pc);
            end else begin
                delivery_t e;
                e = expQ.pop_front();
                checkOutput("deliver_instr", bus.if_instr, e.instr);
                checkOutput("deliver_pc", bus.if_pc, e.pc);
            end
        end
    end

    // One full fetch starting in REQ at posedge+1; ends back in REQ at posedge+1.
    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] d, input int waitCyc,
                                 input int holdCyc, input bit spurious, input bit flushHold);
        pc = p;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        checkOutput("req_high", {31'd0, bus.imem_req}, 32'd1);
        checkOutput("req_addr", bus.imem_addr, p);
        checkOutput("stall_on_gnt", {31'd0, pc_stall}, 32'd0);
        tick();
        bus.imem_gnt = 1'b0;
        if (p[1:0] != 2'b00) expMisalign = 1'b1;
        for (int i = 0; i < waitCyc; i++) begin
            @(negedge clk);
            checkOutput("wait_req_low", {31'd0, bus.imem_req}, 32'd0);
            checkOutput("wait_stall", {31'd0, pc_stall}, 32'd1);
            tick();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        if (!flushHold) expQ.push_back('{instr: d, pc: p});
        @(negedge clk);
        checkOutput("misalign", {31'd0, misalign}, {31'd0, expMisalign});
        checkOutput("valid_before_rsp", {31'd0, bus.if_valid}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < holdCyc; i++) begin
            if (spurious) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ~d;
            end
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, bus.if_valid}, 32'd1);
            checkOutput("hold_instr", bus.if_instr, d);
            checkOutput("hold_pc", bus.if_pc, p);
            checkOutput("hold_req_low", {31'd0, bus.imem_req}, 32'd0);
            checkOutput("hold_stall", {31'd0, pc_stall}, 32'd1);
            checkOutput("hold_count", fetch_count, expCount);
            tick();
            bus.imem_rvalid = 1'b0;
        end
        if (flushHold) begin
            flush = 1'b1;
            bus.id_ready = 1'b1;
            @(negedge clk);
            checkOutput("stall_on_flush", {31'd0, pc_stall}, 32'd0);
            tick();
            flush = 1'b0;
            bus.id_ready = 1'b0;
        end else begin
            bus.id_ready = 1'b1;
            tick();
            bus.id_ready = 1'b0;
            expCount = expCount + 32'd1;
        end
        @(negedge clk);
        checkOutput("after_count", fetch_count, expCount);
        checkOutput("after_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("after_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        expCount         = 32'd0;
        expMisalign      = 1'b0;
        rstn             = 1'b0;
        pc               = 32'd0;
        flush            = 1'b0;
        bus.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 32'd0;
        bus.id_ready     = 1'b0;

        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("rst_count", fetch_count, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        rstn = 1'b1;

        applyStimulus(32'h0000_0000, 32'h2008_0005, 0, 0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0004, 32'h00A0_0093, 1, 5, 1'b0, 1'b0);

        // Flush while waiting: DEADBEEF must never reach decode.
        pc = 32'h0000_0010;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        flush = 1'b1;
        pc = 32'h0000_0040;
        @(negedge clk);
        checkOutput("wait_flush_stall", {31'd0, pc_stall}, 32'd0);
        tick();
        flush = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("drop_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("redirect_addr", bus.imem_addr, 32'h0000_0040);
        tick();
        applyStimulus(32'h0000_0040, 32'h1111_2222, 0, 1, 1'b0, 1'b0);

        // Flush and grant together: old PC issued but its response discarded.
        pc = 32'h0000_0014;
        flush = 1'b1;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        checkOutput("flushgnt_stall", {31'd0, pc_stall}, 32'd0);
        checkOutput("flushgnt_addr", bus.imem_addr, 32'h0000_0014);
        tick();
        flush = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0BAD;
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("flushgnt_valid", {31'd0, bus.if_valid}, 32'd0);
        tick();
        applyStimulus(32'h0000_0080, 32'h3333_4444, 2, 0, 1'b0, 1'b0);

        // Flush while holding: word withdrawn, nothing counted.
        applyStimulus(32'h0000_0084, 32'h5555_6666, 0, 2, 1'b0, 1'b1);

        // Misaligned grant plus spurious rvalid while holding.
        applyStimulus(32'h0000_0006, 32'h7777_8888, 0, 3, 1'b1, 1'b0);
        applyStimulus(32'h0000_0008, 32'h9999_AAAA, 0, 0, 1'b0, 1'b0);

        // Counter wrap from all-ones.
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        expCount = 32'hFFFF_FFFF;
        applyStimulus(32'h0000_000C, 32'hBBBB_CCCC, 0, 0, 1'b0, 1'b0);

        // Reset while a request is outstanding.
        pc = 32'h0000_0020;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        expCount    = 32'd0;
        expMisalign = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("midrst_count", fetch_count, 32'd0);
        checkOutput("midrst_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("midrst_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        applyStimulus(32'h0000_0100, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b0);

        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
